// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit_serializer block: FSM state encodings,
// default geometry and the slot-counter width helper.
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_IDLE_GAP = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // One counter serves both the data slots and the gap, so it must hold the larger of the two.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bit_serializer_slot.sv
// Loadable up-counter with a runtime terminal value; saturates at the terminal
// value so it never wraps inside a word or gap.
module slot_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc && (r_count != i_term)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts a word on valid/ready and emits it MSB-first
// on en/d, followed by IDLE_GAP quiet cycles. Define SERIALIZER_PARITY_EN for an even-parity slot.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int IDLE_GAP = DEFAULT_IDLE_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             en,
  output logic             d,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W      = cnt_width(WIDTH, IDLE_GAP);
  localparam logic [CNT_W-1:0] SHIFT_TERM = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_TERM   = (IDLE_GAP > 0) ? CNT_W'(IDLE_GAP - 1) : '0;
  localparam state_t           POST_DATA  = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
`ifndef SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] PRE_TERM   = CNT_W'(WIDTH - 2);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_en;
  logic             r_d;
  logic             r_busy;
  logic             r_done;
  logic             w_en_nxt;
  logic             w_d_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_hs;
  logic             w_cnt_load;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_term;
  logic [CNT_W-1:0] w_count;
  logic             w_tc;
`ifdef SERIALIZER_PARITY_EN
  logic             r_par;
`endif

  assign in_ready = (r_state == ST_IDLE);
  assign w_hs     = in_valid & in_ready;
  assign w_term   = (r_state == ST_GAP) ? GAP_TERM : SHIFT_TERM;

  slot_counter #(
    .CNT_W (CNT_W)
  ) u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_cnt_load),
    .i_inc   (w_cnt_inc),
    .i_term  (w_term),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_load  = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = in_data;
          w_cnt_load  = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shreg_nxt = r_shreg << 1;
        if (w_tc) begin
`ifdef SERIALIZER_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          w_state_nxt = POST_DATA;
`endif
          w_cnt_load  = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PAR: begin
        w_state_nxt = POST_DATA;
        w_cnt_load  = 1'b1;
      end
`endif
      ST_GAP: begin
        if (w_tc) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_en_nxt   = 1'b0;
    w_d_nxt    = 1'b0;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_SHIFT: begin
        w_en_nxt = 1'b1;
        w_d_nxt  = w_shreg_nxt[WIDTH-1];
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PAR: begin
        w_en_nxt = 1'b1;
        w_d_nxt  = r_par;
      end
`endif
      default: begin
        w_en_nxt = 1'b0;
        w_d_nxt  = 1'b0;
      end
    endcase
`ifdef SERIALIZER_PARITY_EN
    w_done_nxt = (r_state == ST_SHIFT) && (w_count == SHIFT_TERM);
`else
    w_done_nxt = (r_state == ST_SHIFT) && (w_count == PRE_TERM);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_en    <= 1'b0;
      r_d     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_en    <= w_en_nxt;
      r_d     <= w_d_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_hs) begin
      r_par <= ^in_data;
    end
  end
`endif

  assign en   = r_en;
  assign d    = r_d;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: two instances (IDLE_GAP=1 and IDLE_GAP=0) each
// feeding a model of the downstream enable/data stage; parity slot when SERIALIZER_PARITY_EN is defined.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data1, in_data0;
  logic         in_valid1, in_valid0;
  logic         in_ready1, en1, d1, busy1, done1;
  logic         in_ready0, en0, d0, busy0, done0;
  logic         q1, q0;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .IDLE_GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .en(en1), .d(d1), .busy(busy1), .done(done1)
  );

  bit_serializer #(.WIDTH(W), .IDLE_GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .en(en0), .d(d0), .busy(busy0), .done(done0)
  );

  // Downstream stage: captures d on en, clears to 0 otherwise.
  always_ff @(posedge clk) begin
    q1 <= en1 & d1;
    q0 <= en0 & d0;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sample(input int which, output logic e, output logic dd, output logic b,
                        output logic dn, output logic r, output logic qq);
    if (which == 1) begin
      e = en1; dd = d1; b = busy1; dn = done1; r = in_ready1; qq = q1;
    end else begin
      e = en0; dd = d0; b = busy0; dn = done0; r = in_ready0; qq = q0;
    end
  endtask

  // Called with the first slot of word w visible; returns at the first cycle after the word.
  task automatic expect_word(input int which, input logic [W-1:0] w, input string tag, input bit noise);
    logic e, dd, b, dn, r, qq;
    logic expbit, prev;
    int   nslot;
    nslot = W + NPAR;
    prev  = 1'b0;
    for (int k = 0; k < nslot; k++) begin
      sample(which, e, dd, b, dn, r, qq);
      expbit = (k < W) ? w[W-1-k] : ^w;
      check_eq({tag, " en"}, 32'(e), 32'(1));
      check_eq({tag, " d"}, 32'(dd), 32'(expbit));
      check_eq({tag, " done"}, 32'(dn), 32'(k == nslot - 1));
      check_eq({tag, " busy"}, 32'(b), 32'(1));
      check_eq({tag, " in_ready"}, 32'(r), 32'(0));
      if (k > 0) check_eq({tag, " q"}, 32'(qq), 32'(prev));
      prev = expbit;
      if (noise) begin
        in_valid1 = 1'($urandom_range(0, 1));
        in_data1  = W'($urandom);
      end
      @(negedge clk);
    end
    sample(which, e, dd, b, dn, r, qq);
    check_eq({tag, " post en"}, 32'(e), 32'(0));
    check_eq({tag, " post d"}, 32'(dd), 32'(0));
    check_eq({tag, " post done"}, 32'(dn), 32'(0));
    check_eq({tag, " post q"}, 32'(qq), 32'(prev));
    check_eq({tag, " post busy"}, 32'(b), 32'(which == 1));
    check_eq({tag, " post in_ready"}, 32'(r), 32'(which != 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] c3;
    in_valid1 = 1'b0; in_valid0 = 1'b0;
    in_data1  = '0;   in_data0  = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst en", 32'(en1), 32'(0));
    check_eq("rst d", 32'(d1), 32'(0));
    check_eq("rst busy", 32'(busy1), 32'(0));
    check_eq("rst done", 32'(done1), 32'(0));
    check_eq("rst in_ready", 32'(in_ready1), 32'(1));
    check_eq("rst en0", 32'(en0), 32'(0));
    check_eq("rst in_ready0", 32'(in_ready0), 32'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word A5
    in_data1 = 8'hA5; in_valid1 = 1'b1;
    check_eq("t1 ready", 32'(in_ready1), 32'(1));
    @(negedge clk);
    in_valid1 = 1'b0;
    expect_word(1, 8'hA5, "t1", 1'b0);
    @(negedge clk);
    check_eq("t1 idle ready", 32'(in_ready1), 32'(1));
    check_eq("t1 idle busy", 32'(busy1), 32'(0));
    check_eq("t1 idle en", 32'(en1), 32'(0));

    // 2: in_valid held across FF then 00
    in_data1 = 8'hFF; in_valid1 = 1'b1;
    @(negedge clk);
    in_data1 = 8'h00;
    expect_word(1, 8'hFF, "t2a", 1'b0);
    @(negedge clk);
    check_eq("t2 idle ready", 32'(in_ready1), 32'(1));
    check_eq("t2 idle en", 32'(en1), 32'(0));
    @(negedge clk);
    in_valid1 = 1'b0;
    expect_word(1, 8'h00, "t2b", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t2 no third en", 32'(en1), 32'(0));
      check_eq("t2 no third busy", 32'(busy1), 32'(0));
    end

    // 3: reset mid-word C3
    c3 = 8'hC3;
    in_data1 = c3; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("t3 en", 32'(en1), 32'(1));
      check_eq("t3 d", 32'(d1), 32'(c3[W-1-k]));
      @(negedge clk);
    end
    check_eq("t3 pre en", 32'(en1), 32'(1));
    rst_n = 1'b0;
    #1;
    check_eq("t3 abort en", 32'(en1), 32'(0));
    check_eq("t3 abort d", 32'(d1), 32'(0));
    check_eq("t3 abort busy", 32'(busy1), 32'(0));
    check_eq("t3 abort in_ready", 32'(in_ready1), 32'(1));
    @(negedge clk);
    check_eq("t3 q cleared", 32'(q1), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t3 quiet en", 32'(en1), 32'(0));
      check_eq("t3 no done", 32'(done1), 32'(0));
      check_eq("t3 quiet q", 32'(q1), 32'(0));
    end

    // 4: word 07 (parity slot d=1 when enabled)
    in_data1 = 8'h07; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    expect_word(1, 8'h07, "t4", 1'b0);
    @(negedge clk);

    // 5: IDLE_GAP=0 instance, back-to-back 80 then 01
    in_data0 = 8'h80; in_valid0 = 1'b1;
    @(negedge clk);
    in_data0 = 8'h01;
    expect_word(0, 8'h80, "t5a", 1'b0);
    @(negedge clk);
    in_valid0 = 1'b0;
    expect_word(0, 8'h01, "t5b", 1'b0);
    @(negedge clk);
    check_eq("t5 quiet en", 32'(en0), 32'(0));

    // 6: noisy in_valid/in_data while busy
    in_data1 = 8'h5A; in_valid1 = 1'b1;
    @(negedge clk);
    expect_word(1, 8'h5A, "t6", 1'b1);
    in_valid1 = 1'b0;
    @(negedge clk);
    check_eq("t6 idle ready", 32'(in_ready1), 32'(1));
    check_eq("t6 idle en", 32'(en1), 32'(0));
    @(negedge clk);
    check_eq("t6 no extra word", 32'(en1), 32'(0));
    check_eq("t6 no extra busy", 32'(busy1), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
